seg7_onehot_decoder: RTL and testbench

//   Receive side of the 3-bit 7-segment display path: samples an active-low
//   7-segment pattern (digits 0-7), debounces it, and decodes it back to a
//   3-bit index and an 8-bit one-hot vector. Results are offered on a

---
 rtl/seg7_onehot_decoder_if.sv | 11 +
 rtl/seg7_onehot_decoder.sv | 145 ++++++++++++++
 tb/tb_seg7_onehot_decoder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_onehot_decoder_if.sv
// Output bundle of the 7-segment decoder: decoded digit offered with a
// valid/ready handshake. The decoder drives it as master; the consumer is the slave.
interface seg7_onehot_decoder_if;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] idx;
   logic [7:0] onehot;

   modport master (output out_valid, idx, onehot, input out_ready);
   modport slave  (input out_valid, idx, onehot, output out_ready);
endinterface

// File: rtl/seg7_onehot_decoder.sv
// Debounces an active-low 7-segment pattern (digits 0-7) and decodes it to a
// 3-bit index plus one-hot vector, offered on a valid/ready handshake.
module seg7_onehot_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [6:0]                seg_in,
   seg7_onehot_decoder_if.master     res,
   output logic                      err,
   output logic [CNT_W-1:0]          dec_cnt
);

   localparam int                STAB_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
   localparam logic [6:0]        BLANK     = 7'h7F;
   localparam logic              ONE_SHOT  = (STABLE_CYCLES == 1);

   typedef enum logic [1:0] {IDLE, TRACK, HOLD, WAIT_CHG} state_t;

   state_t            state, state_nx;
   logic [6:0]        sample, sample_nx;
   logic [STAB_W-1:0] stab, stab_nx;
   logic              valid_q, valid_nx;
   logic [2:0]        idx_q, idx_nx;
   logic [7:0]        onehot_q, onehot_nx;
   logic              err_nx;
   logic [CNT_W-1:0]  cnt_nx;
   logic              fire;
   logic [3:0]        lut;

   // Returns {legal, digit} for an active-low pattern.
   function automatic logic [3:0] lookup(input logic [6:0] p);
      case (p)
         7'h40:   lookup = 4'b1_000;
         7'h79:   lookup = 4'b1_001;
         7'h24:   lookup = 4'b1_010;
         7'h30:   lookup = 4'b1_011;
         7'h19:   lookup = 4'b1_100;
         7'h12:   lookup = 4'b1_101;
         7'h02:   lookup = 4'b1_110;
         7'h78:   lookup = 4'b1_111;
         default: lookup = 4'b0_000;
      endcase
   endfunction

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_nx  = state;
      sample_nx = sample;
      stab_nx   = stab;
      valid_nx  = valid_q;
      idx_nx    = idx_q;
      onehot_nx = onehot_q;
      err_nx    = 1'b0;
      cnt_nx    = dec_cnt;
      fire      = 1'b0;
      lut       = 4'b0_000;

      case (state)
         IDLE: begin
            if (en && seg_in != BLANK) begin
               sample_nx = seg_in;
               stab_nx   = STAB_W'(1);
               state_nx  = TRACK;
               fire      = ONE_SHOT;
            end
         end
         TRACK: begin
            if (!en || seg_in == BLANK) begin
               state_nx = IDLE;
            end else if (seg_in != sample) begin
               sample_nx = seg_in;
               stab_nx   = STAB_W'(1);
               fire      = ONE_SHOT;
            end else begin
               if (stab <= STAB_LAST) stab_nx = stab + STAB_W'(1);
               fire = (stab == STAB_LAST);
            end
         end
         HOLD: begin
            if (res.out_ready) begin
               valid_nx = 1'b0;
               if (dec_cnt != '1) cnt_nx = dec_cnt + CNT_W'(1);
               state_nx = WAIT_CHG;
            end
         end
         WAIT_CHG: begin
            if (!en || seg_in == BLANK) begin
               state_nx = IDLE;
            end else if (seg_in != sample) begin
               sample_nx = seg_in;
               stab_nx   = STAB_W'(1);
               state_nx  = TRACK;
               fire      = ONE_SHOT;
            end
         end
         default: state_nx = IDLE;
      endcase

      // Pattern has been stable long enough: publish it or flag it once.
      if (fire) begin
         lut = lookup(sample_nx);
         if (lut[3]) begin
            valid_nx  = 1'b1;
            idx_nx    = lut[2:0];
            onehot_nx = 8'b1 << lut[2:0];
            state_nx  = HOLD;
         end else begin
            err_nx   = 1'b1;
            state_nx = WAIT_CHG;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments only.
      if (!rst_n) begin
         state    <= IDLE;
         sample   <= BLANK;
         stab     <= '0;
         valid_q  <= 1'b0;
         idx_q    <= 3'd0;
         onehot_q <= 8'h00;
         err      <= 1'b0;
         dec_cnt  <= '0;
      end else begin
         state    <= state_nx;
         sample   <= sample_nx;
         stab     <= stab_nx;
         valid_q  <= valid_nx;
         idx_q    <= idx_nx;
         onehot_q <= onehot_nx;
         err      <= err_nx;
         dec_cnt  <= cnt_nx;
      end
   end

   assign res.out_valid = valid_q;
   assign res.idx       = idx_q;
   assign res.onehot    = onehot_q;

endmodule

// File: tb/tb_seg7_onehot_decoder.sv
// Self-checking bench for seg7_onehot_decoder: directed vector table, corner
// sequences and randomized traffic against a run-length reference model.
module tb_seg7_onehot_decoder;

   localparam int STAB = 4;

   logic       clk = 1'b0;
   logic       rst_n, en;
   logic [6:0] seg_in;
   logic       err, err2;
   logic [7:0] cnt;
   logic [1:0] cnt2;

   seg7_onehot_decoder_if res ();
   seg7_onehot_decoder_if res2 ();

   seg7_onehot_decoder #(.STABLE_CYCLES(STAB), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .seg_in(seg_in),
      .res(res.master), .err(err), .dec_cnt(cnt));

   seg7_onehot_decoder #(.STABLE_CYCLES(STAB), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .en(en), .seg_in(seg_in),
      .res(res2.master), .err(err2), .dec_cnt(cnt2));

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: counts consecutive identical samples; a consumed or
   // rejected pattern stays blocked until the input changes or blanks.
   logic [6:0] codes [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
   logic       m_valid, m_err;
   logic [2:0] m_idx;
   logic [7:0] m_oh;
   int         m_cnt, m_run;
   logic [6:0] m_pat;
   bit         m_block;

   task automatic model_step(input logic r, input logic e, input logic [6:0] s, input logic rdy);
      bit found;
      int ki;
      m_err = 1'b0;
      if (!r) begin
         m_valid = 0; m_idx = 0; m_oh = 0; m_cnt = 0; m_run = 0; m_block = 0; m_pat = 7'h7F;
         return;
      end
      if (m_valid) begin
         if (rdy) begin
            m_valid = 0;
            m_cnt++;
            m_block = 1;
         end
         return;
      end
      if (!e || s == 7'h7F) begin
         m_run = 0;
         m_block = 0;
         return;
      end
      if (m_block && s == m_pat) return;
      if (!m_block && m_run > 0 && s == m_pat) m_run++;
      else begin
         m_pat = s;
         m_run = 1;
      end
      m_block = 0;
      if (m_run == STAB) begin
         m_run = 0;
         found = 0;
         ki = 0;
         for (int k = 0; k < 8; k++) if (codes[k] == m_pat) begin found = 1; ki = k; end
         if (found) begin
            m_valid = 1;
            m_idx   = 3'(ki);
            m_oh    = 8'h01 << ki;
         end else begin
            m_err   = 1;
            m_block = 1;
         end
      end
   endtask

   task automatic cycle(input logic r, input logic e, input logic [6:0] s, input logic rdy);
      rst_n = r; en = e; seg_in = s;
      res.out_ready = rdy; res2.out_ready = rdy;
      @(posedge clk);
      model_step(r, e, s, rdy);
      #1;
      check("valid",   res.out_valid, m_valid);
      check("idx",     res.idx,       m_idx);
      check("onehot",  res.onehot,    m_oh);
      check("err",     err,           m_err);
      check("dec_cnt", cnt,  (m_cnt > 255) ? 255 : m_cnt);
      check("cnt_sat", cnt2, (m_cnt > 3) ? 3 : m_cnt);
      check("valid2",  res2.out_valid, m_valid);
      check("err_and_valid", err && res.out_valid, 1'b0);
   endtask

   typedef struct {
      logic r, e; logic [6:0] s; logic rdy;
      logic v; logic [2:0] i; logic [7:0] oh; logic er;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(input logic r, e, input logic [6:0] s, input logic rdy,
                               input logic v, input logic [2:0] i, input logic [7:0] oh, input logic er);
      vec_t x;
      x.r = r; x.e = e; x.s = s; x.rdy = rdy; x.v = v; x.i = i; x.oh = oh; x.er = er;
      tbl.push_back(x);
   endfunction

   initial begin
      int base, pulses, hold;
      logic [6:0] pat;
      logic e_r, r_r;

      // Reset held with a legal digit present, then first cycle after release.
      add(0,1,7'h40,1, 0,0,8'h00,0);
      add(0,1,7'h40,1, 0,0,8'h00,0);
      add(1,1,7'h40,1, 0,0,8'h00,0);
      add(1,1,7'h7F,1, 0,0,8'h00,0);
      // Plain decode of 2 with four-cycle latency, accepted at once.
      for (int k = 0; k < 3; k++) add(1,1,7'h24,1, 0,0,8'h00,0);
      add(1,1,7'h24,1, 1,2,8'h04,0);
      add(1,1,7'h24,1, 0,2,8'h04,0);
      add(1,1,7'h7F,1, 0,2,8'h04,0);
      // Glitch of 1 for two cycles, then 7 held: only 7 decodes.
      add(1,1,7'h79,1, 0,2,8'h04,0);
      add(1,1,7'h79,1, 0,2,8'h04,0);
      for (int k = 0; k < 3; k++) add(1,1,7'h78,1, 0,2,8'h04,0);
      add(1,1,7'h78,1, 1,7,8'h80,0);
      add(1,1,7'h78,1, 0,7,8'h80,0);
      add(1,1,7'h78,1, 0,7,8'h80,0);
      add(1,1,7'h7F,1, 0,7,8'h80,0);
      // Illegal pattern: one err pulse, then 5 decodes.
      for (int k = 0; k < 3; k++) add(1,1,7'h00,1, 0,7,8'h80,0);
      add(1,1,7'h00,1, 0,7,8'h80,1);
      add(1,1,7'h00,1, 0,7,8'h80,0);
      for (int k = 0; k < 3; k++) add(1,1,7'h12,1, 0,7,8'h80,0);
      add(1,1,7'h12,1, 1,5,8'h20,0);
      add(1,1,7'h12,1, 0,5,8'h20,0);
      add(1,1,7'h7F,1, 0,5,8'h20,0);

      for (int n = 0; n < tbl.size(); n++) begin
         cycle(tbl[n].r, tbl[n].e, tbl[n].s, tbl[n].rdy);
         check($sformatf("tbl%0d_valid", n),  res.out_valid, tbl[n].v);
         check($sformatf("tbl%0d_idx", n),    res.idx,       tbl[n].i);
         check($sformatf("tbl%0d_onehot", n), res.onehot,    tbl[n].oh);
         check($sformatf("tbl%0d_err", n),    err,           tbl[n].er);
      end
      check("tbl_dec_cnt", cnt, 3);

      // Backpressure: HOLD ignores input changes and en while out_ready=0.
      for (int k = 0; k < 4; k++) cycle(1, 1, 7'h30, 0);
      check("bp_valid", res.out_valid, 1'b1);
      for (int k = 0; k < 10; k++) begin
         cycle(1, 1'($urandom_range(0, 1)), 7'($urandom), 0);
         check("bp_hold_valid",  res.out_valid, 1'b1);
         check("bp_hold_idx",    res.idx,       3);
         check("bp_hold_onehot", res.onehot,    8'h08);
      end
      base = 3;
      cycle(1, 1, 7'h7F, 1);
      check("bp_accept_valid", res.out_valid, 1'b0);
      check("bp_accept_cnt",   cnt, base + 1);

      // Reset wins over a pending handshake.
      for (int k = 0; k < 4; k++) cycle(1, 1, 7'h19, 0);
      check("rst_pend_valid", res.out_valid, 1'b1);
      cycle(0, 1, 7'h19, 1);
      check("rst_ovr_valid", res.out_valid, 1'b0);
      check("rst_ovr_cnt",   cnt, 0);

      // Saturation of the 2-bit counter, then a held digit decodes once.
      for (int d = 0; d < 4; d++) begin
         for (int k = 0; k < 5; k++) cycle(1, 1, 7'h30, 1);
         cycle(1, 1, 7'h7F, 1);
      end
      check("sat_cnt2", cnt2, 2'd3);
      check("sat_cnt8", cnt, 4);
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         cycle(1, 1, 7'h30, 1);
         pulses += int'(res.out_valid);
      end
      check("held_once", pulses, 1);

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 19))
            0, 1, 2:  pat = 7'h7F;
            3, 4, 5:  pat = 7'($urandom);
            default:  pat = codes[$urandom_range(0, 7)];
         endcase
         hold = $urandom_range(1, 7);
         for (int k = 0; k < hold; k++) begin
            e_r = ($urandom_range(0, 9) != 0);
            r_r = ($urandom_range(0, 299) != 0);
            cycle(r_r, e_r, pat, 1'($urandom_range(0, 4) < 3));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
